pipe_mdu_ctrl: RTL

- Sequencer for an iterative 32x32 multiply/divide unit alongside the EX stage of the 5-stage pipeline.
- Accepts an operation from EX and runs it as one shift-add (multiply) or restoring (divide) step per cycle.
- Holds the pipeline through `estall` until the result is committed to the internal HI/LO registers.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/mdu_step.sv | 43 ++++
 rtl/pipe_mdu_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline multiply/divide unit: op encodings,
// sequencer states and the datapath width.
package pipe_pkg;

  localparam int unsigned XLEN = 32;

  // emdop encodings: bit 1 selects divide, bit 0 selects signed
  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } md_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath.
// Multiply: conditional add of the multiplicand into acc, then shift {acc, mq} right.
// Divide:   shift {acc, mq} left, trial-subtract the divisor, set quotient bit on success.
module mdu_step
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] mq,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] acc_nx,
  output logic [XLEN-1:0] mq_nx
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shl;
  logic [XLEN-1:0] diff;
  logic            fits;

  // Single shift-add or restoring-subtract step
  always_comb begin
    sum  = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    shl  = {acc, mq[XLEN-1]};
    fits = (shl >= {1'b0, opnd});
    // When the subtract fits, the true difference is below opnd, so XLEN bits suffice
    diff = shl[XLEN-1:0] - opnd;
    if (is_div) begin
      if (fits) begin
        acc_nx = diff;
        mq_nx  = {mq[XLEN-2:0], 1'b1};
      end else begin
        acc_nx = shl[XLEN-1:0];
        mq_nx  = {mq[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_nx = sum[XLEN:1];
      mq_nx  = {sum[0], mq[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/pipe_mdu_ctrl.sv
// Iterative 32x32 multiply/divide sequencer beside the EX stage.
// Runs one step per cycle on operand magnitudes, applies sign fixup in FIX,
// and stalls the front of the pipeline until HI/LO are written.
// Optional: MDU_EARLY_OUT_EN finishes a multiply as soon as the remaining
// multiplier bits are all zero.
module pipe_mdu_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            estart,
  input  logic [1:0]      emdop,
  input  logic [XLEN-1:0] ea,
  input  logic [XLEN-1:0] eb,
  output logic            estall,
  output logic            edone,
  output logic            ediv0,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  import pipe_pkg::*;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(XLEN - 1);

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            div_q, div_d;
  logic [XLEN-1:0] acc_q, acc_d;     // product high half / partial remainder
  logic [XLEN-1:0] mq_q, mq_d;       // multiplier shifting out / quotient shifting in
  logic [XLEN-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            div0_q, div0_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            ediv0_q, ediv0_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] acc_nx, mq_nx;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix;

`ifdef MDU_EARLY_OUT_EN
  logic [XLEN-1:0]   rem_mask;
  logic [CNT_W-1:0]  sh_amt;
  logic [2*XLEN-1:0] pair_sh;
  logic              early;
`endif

  mdu_step #(
    .XLEN (XLEN)
  ) u_step (
    .is_div (div_q),
    .acc    (acc_q),
    .mq     (mq_q),
    .opnd   (opnd_q),
    .acc_nx (acc_nx),
    .mq_nx  (mq_nx)
  );

  // Operand magnitudes and signs for the op being presented
  always_comb begin
    a_neg = md_is_signed(emdop) & ea[XLEN-1];
    b_neg = md_is_signed(emdop) & eb[XLEN-1];
    a_mag = a_neg ? -ea : ea;
    b_mag = b_neg ? -eb : eb;
  end

  // Sign fixup of the finished magnitude result
  always_comb begin
    prod_fix = neg_res_q ? -{acc_q, mq_q} : {acc_q, mq_q};
    // A zero divisor leaves the quotient as all ones regardless of sign
    quot_fix = (neg_res_q && !div0_q) ? -mq_q : mq_q;
    rem_fix  = neg_rem_q ? -acc_q : acc_q;
  end

`ifdef MDU_EARLY_OUT_EN
  // Detect a multiply whose unconsumed multiplier bits above this step are zero
  always_comb begin
    rem_mask = {XLEN{1'b1}} >> cnt_q;
    early    = !div_q && (((mq_q & rem_mask) >> 1) == '0);
    sh_amt   = LastCnt - cnt_q;
    pair_sh  = {acc_nx, mq_nx} >> sh_amt;
  end
`endif

  // Next-state logic for the FSM and datapath registers
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    ediv0_d   = ediv0_q;
    case (state_q)
      ST_IDLE: begin
        if (estart) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          div_d     = md_is_div(emdop);
          acc_d     = '0;
          mq_d      = md_is_div(emdop) ? a_mag : b_mag;
          opnd_d    = md_is_div(emdop) ? b_mag : a_mag;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = md_is_div(emdop) && (eb == '0);
          if (md_is_div(emdop)) begin
            ediv0_d = 1'b0;
          end
        end
      end
      ST_RUN: begin
        acc_d = acc_nx;
        mq_d  = mq_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = ST_FIX;
        end
`ifdef MDU_EARLY_OUT_EN
        if (early) begin
          {acc_d, mq_d} = pair_sh;
          state_d       = ST_FIX;
        end
`endif
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
          if (div0_q) begin
            ediv0_d = 1'b1;
          end
        end else begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any op in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      acc_q     <= '0;
      mq_q      <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      ediv0_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      ediv0_q   <= ediv0_d;
    end
  end

  // Outputs
  always_comb begin
    estall = ((state_q == ST_IDLE) && estart) || (state_q == ST_RUN) || (state_q == ST_FIX);
    edone  = (state_q == ST_FIX);
    ediv0  = ediv0_q;
    hi     = hi_q;
    lo     = lo_q;
  end

endmodule
